sfifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one synchronous FIFO write port among
//  NIN requesters. Each requester offers beats via req/ack handshake.
//  The arbiter grants one requester at a time, holding the grant for a whole

---
 rtl/sfifo_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sfifo_wr_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_wr_arbiter.sv
// sfifo_wr_arbiter
//
// Round-robin arbiter that shares one synchronous FIFO write port among NIN
// requesters. A requester keeps the grant for a whole packet (OPT_PACKET=1)
// or for up to MAXBURST accepted beats (OPT_PACKET=0). Every release costs one
// idle cycle before the next grant is issued.
//
// Ports
//   i_clk      clock; all state changes on the rising edge
//   i_reset_n  asynchronous active-low reset
//   i_req      per-requester beat valid
//   i_last     per-requester last-beat-of-packet flag (packet mode only)
//   i_data     requester k data at [k*BW +: BW]
//   o_ack      beat of requester k accepted this cycle (combinational)
//   o_grant    registered one-hot grant, zero while idle
//   o_wr       FIFO write strobe
//   o_data     FIFO write data (granted requester's data, zero while idle)
//   i_full     FIFO full; blocks acceptance without dropping the grant

module sfifo_wr_arbiter #(
  parameter int unsigned NIN        = 4,
  parameter int unsigned LGNIN      = 2,
  parameter int unsigned BW         = 8,
  parameter int unsigned MAXBURST   = 4,
  parameter bit          OPT_PACKET = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NIN-1:0]    i_req,
  input  logic [NIN-1:0]    i_last,
  input  logic [NIN*BW-1:0] i_data,
  output logic [NIN-1:0]    o_ack,
  output logic [NIN-1:0]    o_grant,
  output logic              o_wr,
  output logic [BW-1:0]     o_data,
  input  logic              i_full
);

  localparam int unsigned CW = $clog2(MAXBURST + 1);
  // One extra bit so ptr + 1 + offset can be wrapped without overflow.
  localparam int unsigned PW = LGNIN + 1;

  localparam logic [CW-1:0]    MaxCnt  = CW'(MAXBURST);
  localparam logic [PW-1:0]    NinW    = PW'(NIN);
  localparam logic [LGNIN-1:0] PtrRst  = LGNIN'(NIN - 1);
  localparam logic [NIN-1:0]   OneHot0 = NIN'(1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [NIN-1:0]   grant_q, grant_d;
  logic [LGNIN-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate the request vector so bit j corresponds to
  // requester (ptr + 1 + j) mod NIN, then take the lowest set bit.
  // ---------------------------------------------------------------------------
  logic [2*NIN-1:0] req_dbl;
  logic [2*NIN-1:0] req_rot;
  logic [PW-1:0]    rot_amt;
  logic [PW-1:0]    cand;
  logic             win_found;
  logic [LGNIN-1:0] win_idx;

  assign req_dbl = {i_req, i_req};
  assign rot_amt = {1'b0, ptr_q} + PW'(1);
  assign req_rot = req_dbl >> rot_amt;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned j = 0; j < NIN; j++) begin
      if (!win_found && req_rot[j]) begin
        win_found = 1'b1;
        cand      = rot_amt + PW'(j);
        if (cand >= NinW) begin
          cand = cand - NinW;
        end
        win_idx = cand[LGNIN-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path: only the granted requester can be acked, and only when the
  // FIFO has room. grant_q is zero while idle, which zeroes everything below.
  // ---------------------------------------------------------------------------
  logic [BW-1:0] data_mux;
  logic          g_req;
  logic          g_last;

  assign o_ack   = grant_q & i_req & {NIN{~i_full}};
  assign o_wr    = |o_ack;
  assign o_grant = grant_q;
  assign g_req   = |(grant_q & i_req);
  assign g_last  = |(grant_q & i_last);

  always_comb begin
    data_mux = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (grant_q[k]) begin
        data_mux = data_mux | i_data[k*BW +: BW];
      end
    end
  end

  assign o_data = data_mux;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic rel;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    rel     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StBusy;
          grant_d = OneHot0 << win_idx;
          ptr_d   = win_idx;  // winner becomes lowest priority next round
          count_d = '0;
        end
      end

      StBusy: begin
        // Saturate so long packets never push the count past MAXBURST.
        if (o_wr && (count_q != MaxCnt)) begin
          count_d = count_q + CW'(1);
        end

        if (OPT_PACKET) begin
          rel = o_wr && g_last;
        end else begin
          // A dropped request releases even while the FIFO is full; a full
          // FIFO alone never releases.
          rel = (o_wr && (count_d == MaxCnt)) || !g_req;
        end

        if (rel) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= PtrRst;  // requester 0 has top priority after reset
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Bench for sfifo_wr_arbiter: two instances share stimulus, one in burst mode
// (MAXBURST=4) and one in packet mode. Directed scenarios plus a random run
// checked against a behavioural model of grants, bursts and packets.

module tb_sfifo_wr_arbiter;

  localparam int NIN      = 4;
  localparam int BW       = 8;
  localparam int MAXBURST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic        full;

  logic [3:0] ack0, gnt0, ack1, gnt1;
  logic       wr0, wr1;
  logic [7:0] dat0, dat1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sfifo_wr_arbiter #(
    .NIN(NIN), .LGNIN(2), .BW(BW), .MAXBURST(MAXBURST), .OPT_PACKET(1'b0)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_last(last), .i_data(data),
    .o_ack(ack0), .o_grant(gnt0), .o_wr(wr0), .o_data(dat0), .i_full(full)
  );

  sfifo_wr_arbiter #(
    .NIN(NIN), .LGNIN(2), .BW(BW), .MAXBURST(MAXBURST), .OPT_PACKET(1'b1)
  ) dut_pkt (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_last(last), .i_data(data),
    .o_ack(ack1), .o_grant(gnt1), .o_wr(wr1), .o_data(dat1), .i_full(full)
  );

  // Behavioural model; index 0 = burst mode, 1 = packet mode.
  // m_gnt is the granted requester number, -1 while idle.
  int m_gnt[2];
  int m_ptr[2];
  int m_cnt[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_gnt[m] = -1;
      m_ptr[m] = NIN - 1;
      m_cnt[m] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (m_gnt[m] < 0) begin
        int winner = -1;
        for (int i = 1; i <= NIN; i++) begin
          int k = (m_ptr[m] + i) % NIN;
          if (winner < 0 && req[k]) winner = k;
        end
        if (winner >= 0) begin
          m_gnt[m] = winner;
          m_ptr[m] = winner;
          m_cnt[m] = 0;
        end
      end else begin
        int  g   = m_gnt[m];
        bit  acc = req[g] && !full;
        bit  done;
        if (acc && m_cnt[m] < MAXBURST) m_cnt[m]++;
        if (m == 1) done = acc && last[g];
        else        done = (acc && m_cnt[m] == MAXBURST) || !req[g];
        if (done) m_gnt[m] = -1;
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(int m);
    if (m_gnt[m] < 0) return 4'b0000;
    return 4'(1 << m_gnt[m]);
  endfunction

  function automatic logic [3:0] exp_ack(int m);
    int g = m_gnt[m];
    if (g < 0 || full || !req[g]) return 4'b0000;
    return 4'(1 << g);
  endfunction

  function automatic logic [7:0] exp_data(int m);
    int g = m_gnt[m];
    if (g < 0) return 8'h00;
    return data[g*8 +: 8];
  endfunction

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    full  = 1'b0;
    data  = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    last  = 4'b1111;
    full  = 1'b0;
    data  = 32'hDEADBEEF;
    model_reset();
    for (int e = 0; e < 2; e++) begin
      #1;
      total++;
      if (gnt0 !== 4'b0 || gnt1 !== 4'b0) begin
        bad++;
        $display("FAIL reset_grant: got %b/%b want 0000", gnt0, gnt1);
      end
      total++;
      if (ack0 !== 4'b0 || ack1 !== 4'b0 || wr0 !== 1'b0 || wr1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_ack_wr: ack %b/%b wr %b/%b want 0", ack0, ack1, wr0, wr1);
      end
      total++;
      if (dat0 !== 8'h00 || dat1 !== 8'h00) begin
        bad++;
        $display("FAIL reset_data: got %h/%h want 00", dat0, dat1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    req   = '0;
    last  = '0;
  endtask

  // Requesters 1 and 2 held: 1 gets 4 beats, one idle cycle, then 2.
  task automatic test_two_requesters();
    logic [3:0] eg;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req  = 4'b0110;
      data = 32'hA3A2A1A0;
      #1;
      eg = (c == 0 || c == 5) ? 4'b0000 : (c < 5) ? 4'b0010 : 4'b0100;
      total++;
      if (gnt0 !== eg) begin
        bad++;
        $display("FAIL two_req_grant c=%0d: got %b want %b", c, gnt0, eg);
      end
      total++;
      if (wr0 !== (eg != 0) || ack0 !== eg) begin
        bad++;
        $display("FAIL two_req_ack c=%0d: ack %b wr %b want ack %b", c, ack0, wr0, eg);
      end
      if (c == 1) begin
        total++;
        if (dat0 !== 8'hA1) begin
          bad++;
          $display("FAIL two_req_data: got %h want a1", dat0);
        end
      end
      advance();
    end
  endtask

  // All four request: 0,1,2,3,0 with four beats each and an idle gap.
  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      req  = 4'b1111;
      data = $urandom;
      #1;
      eg = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
      ed = (eg == 0) ? 8'h00 : data[((c / 5) % 4)*8 +: 8];
      total++;
      if (gnt0 !== eg || ack0 !== eg) begin
        bad++;
        $display("FAIL rr c=%0d: grant %b ack %b want %b", c, gnt0, ack0, eg);
      end
      total++;
      if (dat0 !== ed) begin
        bad++;
        $display("FAIL rr_data c=%0d: got %h want %h", c, dat0, ed);
      end
      advance();
    end
  endtask

  // Packet mode: req0 sends 6 beats with a 2-cycle gap while req2 waits.
  task automatic test_packet();
    int         nb    = 0;
    int         beats = 0;
    bit         r0;
    logic [3:0] eg, ea;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      r0   = (c <= 8) && (c != 3) && (c != 4);
      req  = {2'b01, 1'b0, r0};
      last = {3'b000, r0 && nb == 5};
      data = {8'h00, 8'h77, 8'h00, 8'(8'h30 + nb)};
      #1;
      eg = (c == 0 || c == 9) ? 4'b0000 : (c <= 8) ? 4'b0001 : 4'b0100;
      ea = (c >= 1 && c <= 8 && r0) ? 4'b0001 : (c == 10) ? 4'b0100 : 4'b0000;
      total++;
      if (gnt1 !== eg) begin
        bad++;
        $display("FAIL pkt_grant c=%0d: got %b want %b", c, gnt1, eg);
      end
      total++;
      if (ack1 !== ea) begin
        bad++;
        $display("FAIL pkt_ack c=%0d: got %b want %b", c, ack1, ea);
      end
      if (ack1[0]) beats++;
      advance();
      if (c >= 1 && c <= 8 && r0) nb++;
    end
    total++;
    if (beats != 6) begin
      bad++;
      $display("FAIL pkt_beats: got %0d want 6", beats);
    end
  endtask

  // FIFO full for 3 cycles mid-burst: no lost or duplicated beat.
  task automatic test_full();
    logic [7:0] got[$];
    int         sent = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req  = (c <= 7) ? 4'b0001 : 4'b0000;
      full = (c >= 2 && c <= 4);
      data = {24'h0, 8'(8'h10 + sent)};
      #1;
      if (c >= 2 && c <= 4) begin
        total++;
        if (wr0 !== 1'b0 || ack0 !== 4'b0 || gnt0 !== 4'b0001) begin
          bad++;
          $display("FAIL full_hold c=%0d: wr %b ack %b grant %b want 0/0000/0001",
                   c, wr0, ack0, gnt0);
        end
      end
      if (c == 8) begin
        total++;
        if (gnt0 !== 4'b0000) begin
          bad++;
          $display("FAIL full_release: grant %b want 0000", gnt0);
        end
      end
      if (wr0 === 1'b1) begin
        got.push_back(dat0);
        sent++;
      end
      advance();
    end
    full = 1'b0;
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL full_count: got %0d writes want 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== 8'(8'h10 + i)) begin
        bad++;
        $display("FAIL full_order[%0d]: got %h want %h", i, got[i], 8'(8'h10 + i));
      end
    end
  endtask

  // Burst mode: granted req3 drops after 2 beats; req0 wins next.
  task automatic test_drop();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req  = (c <= 2) ? 4'b1000 : 4'b0111;
      data = $urandom;
      #1;
      if (c == 1 || c == 2) begin
        total++;
        if (gnt0 !== 4'b1000 || ack0 !== 4'b1000) begin
          bad++;
          $display("FAIL drop_beat c=%0d: grant %b ack %b want 1000", c, gnt0, ack0);
        end
      end
      if (c == 3) begin
        total++;
        if (gnt0 !== 4'b1000 || ack0 !== 4'b0000) begin
          bad++;
          $display("FAIL drop_noack: grant %b ack %b want 1000/0000", gnt0, ack0);
        end
      end
      if (c == 4) begin
        total++;
        if (gnt0 !== 4'b0000) begin
          bad++;
          $display("FAIL drop_idle: grant %b want 0000", gnt0);
        end
      end
      if (c == 5) begin
        total++;
        if (gnt0 !== 4'b0001) begin
          bad++;
          $display("FAIL drop_next: grant %b want 0001", gnt0);
        end
      end
      advance();
    end
  endtask

  // Reset asserted between clock edges mid-burst.
  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      req  = 4'b1111;
      data = $urandom;
      #1;
      advance();
    end
    req = 4'b1111;
    #1;
    total++;
    if (gnt0 !== 4'b0001) begin
      bad++;
      $display("FAIL areset_pre: grant %b want 0001", gnt0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt0 !== 4'b0 || gnt1 !== 4'b0 || wr0 !== 1'b0 || wr1 !== 1'b0 ||
        ack0 !== 4'b0 || ack1 !== 4'b0) begin
      bad++;
      $display("FAIL areset_drop: grant %b/%b wr %b/%b ack %b/%b want all 0",
               gnt0, gnt1, wr0, wr1, ack0, ack1);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    #1;
    advance();
    #1;
    total++;
    if (gnt0 !== 4'b0001 || gnt1 !== 4'b0001) begin
      bad++;
      $display("FAIL areset_first: grant %b/%b want 0001", gnt0, gnt1);
    end
  endtask

  // Random traffic on both instances against the model.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req  = 4'($urandom);
      last = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      full = ($urandom_range(0, 3) == 0);
      data = $urandom;
      #1;
      total++;
      if (gnt0 !== exp_grant(0) || gnt1 !== exp_grant(1)) begin
        bad++;
        $display("FAIL rnd_grant c=%0d: got %b/%b want %b/%b",
                 c, gnt0, gnt1, exp_grant(0), exp_grant(1));
      end
      total++;
      if (ack0 !== exp_ack(0) || ack1 !== exp_ack(1)) begin
        bad++;
        $display("FAIL rnd_ack c=%0d: got %b/%b want %b/%b",
                 c, ack0, ack1, exp_ack(0), exp_ack(1));
      end
      total++;
      if (wr0 !== (exp_ack(0) != 0) || wr1 !== (exp_ack(1) != 0)) begin
        bad++;
        $display("FAIL rnd_wr c=%0d: got %b/%b", c, wr0, wr1);
      end
      total++;
      if (dat0 !== exp_data(0) || dat1 !== exp_data(1)) begin
        bad++;
        $display("FAIL rnd_data c=%0d: got %h/%h want %h/%h",
                 c, dat0, dat1, exp_data(0), exp_data(1));
      end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    data  = '0;
    full  = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_two_requesters();
    test_round_robin();
    test_packet();
    test_full();
    test_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
